// File: rtl/mem_dump_ctrl.sv
// rtl/mem_dump_ctrl.sv - streams an inclusive RAM address range out over a valid/ready port
module mem_dump_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_adr,
    input  logic [ADDR_WIDTH-1:0] end_adr,
    output logic                  mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_adr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPT, SEND, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH-1:0] end_q;

    assign mem_we = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cur        <= '0;
            end_q      <= '0;
            mem_adr    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            mem_sel    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // busy is high exactly in ISSUE/CAPT/SEND, so it doubles as the abort window
            if (busy && abort) begin
                state      <= IDLE;
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
                mem_sel    <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (start_adr <= end_adr) begin
                                cur     <= start_adr;
                                end_q   <= end_adr;
                                mem_adr <= start_adr;
                                mem_sel <= 1'b1;
                                busy    <= 1'b1;
                                state   <= ISSUE;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    ISSUE: state <= CAPT;
                    CAPT: begin
                        dout       <= mem_din;
                        dout_last  <= (cur == end_q);
                        dout_valid <= 1'b1;
                        state      <= SEND;
                    end
                    SEND: begin
                        if (dout_ready) begin
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                            // end test before increment keeps cur from wrapping past the top address
                            if (cur == end_q) begin
                                done    <= 1'b1;
                                mem_sel <= 1'b0;
                                busy    <= 1'b0;
                                state   <= DONE;
                            end else begin
                                cur     <= cur + 1'b1;
                                mem_adr <= cur + 1'b1;
                                state   <= ISSUE;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb/tb_mem_dump_ctrl.sv - randomized and directed bench for mem_dump_ctrl with a word-level reference model
module tb_mem_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] start_adr = '0;
    logic [11:0] end_adr = '0;
    logic        mem_sel;
    logic [11:0] mem_adr;
    logic        mem_we;
    logic [15:0] mem_din = '0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        dout_last;
    logic        busy;
    logic        done;
    logic        err;

    mem_dump_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .start_adr  (start_adr),
        .end_adr    (end_adr),
        .mem_sel    (mem_sel),
        .mem_adr    (mem_adr),
        .mem_we     (mem_we),
        .mem_din    (mem_din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:4095];
    always @(posedge clk) mem_din <= ram[mem_adr];

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc_cnt);
        end
    endtask

    // Reference model: remaining dump tracked as current/end address plus cycles until the word is presented
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [11:0] m_cur = '0;
    logic [11:0] m_end = '0;
    int          m_cnt = 0;

    int   hs_cyc[$];
    logic [15:0] hs_dat[$];
    logic hs_last[$];
    int   err_cnt = 0, busy_cnt = 0, sel_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic zero_adr = 1'b0;

    always @(negedge clk) begin
        logic nd, ne;
        if (!rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else begin
            chk("mem_we", mem_we, 0);
            chk("busy", busy, m_busy);
            chk("mem_sel", mem_sel, m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("dout_valid", dout_valid, m_busy && m_cnt == 0);
            if (m_busy) chk("mem_adr", mem_adr, m_cur);
            if (m_busy && m_cnt == 0) begin
                chk("dout", dout, ram[m_cur]);
                chk("dout_last", dout_last, m_cur == m_end);
            end
            err_cnt  += int'(err);
            busy_cnt += int'(busy);
            sel_cnt  += int'(mem_sel);
            if (done) begin done_cnt++; done_cyc = cyc_cnt; end
            if (busy && mem_adr == 12'h000) zero_adr = 1'b1;
            if (dout_valid && dout_ready && !abort) begin
                hs_cyc.push_back(cyc_cnt);
                hs_dat.push_back(dout);
                hs_last.push_back(dout_last);
            end
            nd = 1'b0; ne = 1'b0;
            if (m_busy) begin
                if (abort) m_busy = 1'b0;
                else if (m_cnt != 0) m_cnt--;
                else if (dout_ready) begin
                    if (m_cur == m_end) begin m_busy = 1'b0; nd = 1'b1; end
                    else begin m_cur++; m_cnt = 2; end
                end
            end else if (!m_done && start) begin
                if (start_adr <= end_adr) begin
                    m_busy = 1'b1; m_cur = start_adr; m_end = end_adr; m_cnt = 2;
                end else ne = 1'b1;
            end
            m_done = nd;
            m_err  = ne;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [11:0] a, input logic [11:0] b);
        start_adr = a; end_adr = b; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string what);
        int n = 0;
        while (!dout_valid && n < 50) begin cyc(); n++; end
        if (!dout_valid) begin
            checks++; errors++;
            $display("FAIL timeout %s: dout_valid stayed 0, required 1", what);
        end
    endtask

    task automatic wait_idle(input string what);
        int n = 0;
        while ((busy || done) && n < 200) begin cyc(); n++; end
        if (busy || done) begin
            checks++; errors++;
            $display("FAIL timeout %s: busy=%0b done=%0b, required idle", what, busy, done);
        end
    endtask

    task automatic clear_log();
        hs_cyc.delete(); hs_dat.delete(); hs_last.delete();
        err_cnt = 0; busy_cnt = 0; sel_cnt = 0; done_cnt = 0; zero_adr = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " dout"}, dout, 0);
        chk({tag, " mem_adr"}, mem_adr, 0);
        chk({tag, " dout_valid"}, dout_valid, 0);
        chk({tag, " dout_last"}, dout_last, 0);
        chk({tag, " mem_sel"}, mem_sel, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " err"}, err, 0);
    endtask

    initial begin
        logic [15:0] a_vals [4];
        for (int i = 0; i < 4096; i++) ram[i] = 16'($urandom);
        a_vals[0] = 16'h00A1; a_vals[1] = 16'h00A2; a_vals[2] = 16'h00A3; a_vals[3] = 16'h00A4;
        for (int i = 0; i < 4; i++) ram[12'h010 + i] = a_vals[i];
        ram[12'hFFE] = 16'hBEEF;
        ram[12'hFFF] = 16'hCAFE;
        ram[12'h005] = 16'h5A5A;

        #1 rst = 1'b0;
        #2 chk_zero_outputs("reset");
        cyc(); cyc();
        rst = 1'b1;
        cyc();

        // Four-word dump with ready held high
        dout_ready = 1'b1;
        clear_log();
        kick(12'h010, 12'h013);
        wait_idle("four-word dump");
        chk("four-word count", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("four-word data", hs_dat[i], a_vals[i]);
                chk("four-word last", hs_last[i], i == 3);
            end
            for (int i = 0; i < 3; i++) chk("four-word spacing", hs_cyc[i+1] - hs_cyc[i], 3);
            chk("four-word done timing", done_cyc, hs_cyc[3] + 1);
        end
        chk("four-word done count", done_cnt, 1);

        // Reversed range
        clear_log();
        kick(12'h020, 12'h01F);
        cyc(); cyc(); cyc();
        chk("range err pulses", err_cnt, 1);
        chk("range busy cycles", busy_cnt, 0);
        chk("range mem_sel cycles", sel_cnt, 0);

        // Top of address space
        clear_log();
        kick(12'hFFE, 12'hFFF);
        wait_idle("top dump");
        chk("top count", hs_cyc.size(), 2);
        if (hs_cyc.size() == 2) begin
            chk("top data0", hs_dat[0], 16'hBEEF);
            chk("top data1", hs_dat[1], 16'hCAFE);
            chk("top last0", hs_last[0], 0);
            chk("top last1", hs_last[1], 1);
        end
        chk("top done", done_cnt, 1);
        chk("top read of 0x000", zero_adr, 0);

        // Back-pressure: ready low for 5 SEND cycles
        clear_log();
        dout_ready = 1'b0;
        kick(12'h100, 12'h101);
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall valid", dout_valid, 1);
            chk("stall dout", dout, ram[12'h100]);
            chk("stall last", dout_last, 0);
            chk("stall mem_adr", mem_adr, 12'h100);
            cyc();
        end
        dout_ready = 1'b1;
        wait_idle("stall dump");
        chk("stall word count", hs_cyc.size(), 2);

        // Abort on second word's SEND together with ready
        clear_log();
        kick(12'h030, 12'h033);
        begin
            int n = 0;
            while (hs_cyc.size() < 1 && n < 50) begin cyc(); n++; end
        end
        wait_valid("abort second word");
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort mem_sel", mem_sel, 0);
        chk("abort busy", busy, 0);
        chk("abort dout_valid", dout_valid, 0);
        cyc(); cyc(); cyc();
        chk("abort done count", done_cnt, 0);
        chk("abort words accepted", hs_cyc.size(), 1);

        // Reset mid-dump, then a one-word dump
        clear_log();
        kick(12'h040, 12'h048);
        cyc(); cyc(); cyc(); cyc();
        #2 rst = 1'b0;
        #1 chk_zero_outputs("mid reset");
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        chk("mid reset done count", done_cnt, 0);
        clear_log();
        kick(12'h005, 12'h005);
        wait_idle("single word");
        chk("single count", hs_cyc.size(), 1);
        if (hs_cyc.size() == 1) begin
            chk("single data", hs_dat[0], 16'h5A5A);
            chk("single last", hs_last[0], 1);
        end
        chk("single done", done_cnt, 1);

        // Random traffic: start/abort/ready toggling, address inputs changing mid-dump
        for (int c = 0; c < 3000; c++) begin
            dout_ready = ($urandom % 4) != 0;
            abort      = ($urandom % 60) == 0;
            start      = ($urandom % 8) == 0;
            if (start) begin
                logic [11:0] sa;
                int unsigned len;
                sa  = 12'($urandom_range(0, 4095));
                len = $urandom_range(0, 4);
                start_adr = sa;
                end_adr   = (int'(sa) + len > 4095) ? 12'hFFF : 12'(int'(sa) + len);
                if (($urandom % 6) == 0 && sa != 0) end_adr = sa - 12'($urandom_range(1, int'(sa)));
            end else begin
                start_adr = 12'($urandom);
                end_adr   = 12'($urandom);
            end
            cyc();
        end
        start = 1'b0; abort = 1'b0; dout_ready = 1'b1;
        wait_idle("random drain");
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dump_ctrl.md
MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, memory address width (4096 words).
REQ-003 The block SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-006 The block SHALL have port abort  input  1  cancel an active dump.
REQ-007 The block SHALL have port start_adr  input  ADDR_WIDTH  first address to read.
REQ-008 The block SHALL have port end_adr  input  ADDR_WIDTH  last address to read, inclusive.
REQ-009 The block SHALL have port mem_sel  output  1  memory-port claim, drives the top-level sel_in mux.
REQ-010 The block SHALL have port mem_adr  output  ADDR_WIDTH  RAM address.
REQ-011 The block SHALL have port mem_we  output  1  RAM write enable, constant 0.
REQ-012 The block SHALL have port mem_din  input  DATA_WIDTH  RAM read data, valid one cycle after mem_adr.
REQ-013 The block SHALL have port dout  output  DATA_WIDTH  dumped word.
REQ-014 The block SHALL have port dout_valid  output  1  dout holds a word.
REQ-015 The block SHALL have port dout_ready  input  1  sink accepts word when valid&ready.
REQ-016 The block SHALL have port dout_last  output  1  current word is from end_adr.
REQ-017 The block SHALL have ports busy, done, err  output  1 each  dump active; 1-cycle completion pulse; 1-cycle range-error pulse.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, CAPT, SEND, DONE.
REQ-019 In IDLE, start=1 with start_adr<=end_adr SHALL latch both addresses, set cur=start_adr, and go to ISSUE.
REQ-020 In IDLE, start=1 with start_adr>end_adr SHALL pulse err for one cycle and remain in IDLE.
REQ-021 start while not in IDLE SHALL be ignored; latched addresses SHALL not change mid-dump.
REQ-022 ISSUE SHALL drive mem_adr=cur and go to CAPT next cycle.
REQ-023 CAPT SHALL register mem_din into dout, set dout_last=(cur==end), and go to SEND.
REQ-024 SEND SHALL hold dout_valid=1 with dout, dout_last and mem_adr stable until dout_ready=1.
REQ-025 On handshake in SEND: if cur==end go to DONE, else cur=cur+1 and go to ISSUE.
REQ-026 The end test SHALL compare before incrementing, so end_adr=4095 ends without wrapping; cur SHALL never pass 4095.
REQ-027 DONE SHALL pulse done for exactly one cycle, release mem_sel, and return to IDLE.
REQ-028 mem_sel and busy SHALL be 1 exactly in ISSUE, CAPT and SEND.
REQ-029 mem_we SHALL be 0 in every state; the block never writes RAM.
REQ-030 abort=1 in ISSUE/CAPT/SEND SHALL go to IDLE next cycle, drop dout_valid, mem_sel and busy, and not pulse done; abort has priority over handshake in the same cycle.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 Each word SHALL take at least 3 cycles (ISSUE, CAPT, SEND with ready held high).
REQ-033 A one-word dump (start_adr==end_adr) SHALL assert dout_last on its only word.

Reset
REQ-034 rst=0 SHALL immediately force IDLE, cur=0, dout=0, mem_adr=0, and dout_valid, dout_last, mem_sel, busy, done, err all 0, regardless of clock.
REQ-035 Reset asserted mid-dump SHALL abandon the dump without a done pulse; after release the block SHALL accept a new start.

Verification
REQ-036 RAM[0x010..0x013]=A1,A2,A3,A4; start 0x010..0x013, ready=1 -> dout A1..A4 in order, 3 cycles apart, dout_last only on A4, done one cycle after A4 handshake.
REQ-037 start_adr=0x020, end_adr=0x01F -> err pulses one cycle, busy stays 0, mem_sel stays 0.
REQ-038 start 0xFFE..0xFFF -> two words, last on 0xFFF, done, mem_adr never reads 0x000.
REQ-039 ready held 0 for 5 cycles in SEND -> dout, dout_last, mem_adr stable, dout_valid high throughout; word then accepted once.
REQ-040 abort on second word's SEND cycle together with ready=1 -> IDLE next cycle, no done, mem_sel=0; rst=0 mid-dump -> all outputs 0 asynchronously, and a subsequent start 0x005..0x005 returns RAM[0x005] with dout_last=1.
